// File: rtl/mem_boot_loader.sv
// Boot-time memory loader: owns the memory port while the core is held in reset, runs
// fill/load/verify commands over address ranges, then releases the core with a start pulse.
module mem_boot_loader #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned DEPTH          = 2048,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned TRIGGER_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    input  logic [DATA_WIDTH-1:0] cmd_fill,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  mem_owner,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  core_reset_n,
    output logic                  trigger_program,
    output logic                  busy,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] err_addr
);

    typedef enum logic [2:0] {
        StIdle, StFill, StLoad, StVIssue, StVWait, StVCmp, StRun
    } state_e;

    localparam logic [1:0] OpFill   = 2'd0;
    localparam logic [1:0] OpLoad   = 2'd1;
    localparam logic [1:0] OpVerify = 2'd2;
    localparam logic [1:0] OpStart  = 2'd3;

    localparam logic [ADDR_WIDTH:0]   DepthExt = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [1:0]            WaitInit = 2'(READ_LATENCY - 1);
    localparam logic [3:0]            TrigInit = 4'(TRIGGER_CYCLES);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] remain_q, remain_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;
    logic [1:0]            wait_q, wait_d;
    logic [3:0]            trig_q, trig_d;
    logic                  error_q, error_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

    logic [ADDR_WIDTH:0]   base_ext;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  last_word;

    assign base_ext  = {1'b0, cmd_base} % DepthExt;
    assign next_addr = (addr_q == LastAddr) ? '0 : addr_q + ADDR_WIDTH'(1);
    assign last_word = (remain_q == ADDR_WIDTH'(1));
    assign error     = error_q;
    assign err_addr  = err_addr_q;

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        remain_d        = remain_q;
        fill_d          = fill_q;
        wait_d          = wait_q;
        trig_d          = trig_q;
        error_d         = error_q;
        err_addr_d      = err_addr_q;
        cmd_ready       = 1'b0;
        s_ready         = 1'b0;
        mem_owner       = 1'b1;
        mem_we          = 1'b0;
        mem_addr        = addr_q;
        mem_din         = '0;
        core_reset_n    = 1'b0;
        trigger_program = 1'b0;
        busy            = 1'b0;

        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d   = base_ext[ADDR_WIDTH-1:0];
                    remain_d = cmd_len;
                    fill_d   = cmd_fill;
                    unique case (cmd_op)
                        OpFill:   if (cmd_len != '0) state_d = StFill;
                        OpLoad:   if (cmd_len != '0) state_d = StLoad;
                        OpVerify: if (cmd_len != '0) state_d = StVIssue;
                        OpStart: begin
                            // A failed verify blocks launch; the command is still consumed.
                            if (!error_q) begin
                                state_d = StRun;
                                trig_d  = TrigInit;
                            end
                        end
                        default: state_d = StIdle;
                    endcase
                end
            end
            StFill: begin
                busy     = 1'b1;
                mem_we   = 1'b1;
                mem_din  = fill_q;
                addr_d   = next_addr;
                remain_d = remain_q - ADDR_WIDTH'(1);
                if (last_word) state_d = StIdle;
            end
            StLoad: begin
                busy    = 1'b1;
                s_ready = 1'b1;
                if (s_valid) begin
                    mem_we   = 1'b1;
                    mem_din  = s_data;
                    addr_d   = next_addr;
                    remain_d = remain_q - ADDR_WIDTH'(1);
                    if (last_word) state_d = StIdle;
                end
            end
            StVIssue: begin
                busy    = 1'b1;
                wait_d  = WaitInit;
                state_d = (READ_LATENCY > 1) ? StVWait : StVCmp;
            end
            StVWait: begin
                busy   = 1'b1;
                wait_d = wait_q - 2'd1;
                if (wait_q == 2'd1) state_d = StVCmp;
            end
            StVCmp: begin
                busy    = 1'b1;
                s_ready = 1'b1;
                if (s_valid) begin
                    if ((mem_dout != s_data) && !error_q) begin
                        error_d    = 1'b1;
                        err_addr_d = addr_q;
                    end
                    addr_d   = next_addr;
                    remain_d = remain_q - ADDR_WIDTH'(1);
                    state_d  = last_word ? StIdle : StVIssue;
                end
            end
            StRun: begin
                mem_owner       = 1'b0;
                core_reset_n    = 1'b1;
                trigger_program = (trig_q != 4'd0);
                if (trig_q != 4'd0) trig_d = trig_q - 4'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            remain_q   <= '0;
            fill_q     <= '0;
            wait_q     <= '0;
            trig_q     <= '0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            fill_q     <= fill_d;
            wait_q     <= wait_d;
            trig_q     <= trig_d;
            error_q    <= error_d;
            err_addr_q <= err_addr_d;
        end
    end

endmodule

// File: tb/tb_mem_boot_loader.sv
// Directed bench for mem_boot_loader with a behavioural RAM of read latency 2.
module tb_mem_boot_loader;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          reset, cmd_valid, cmd_ready, s_valid, s_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_base, cmd_len, mem_addr, err_addr;
    logic [DW-1:0] cmd_fill, s_data, mem_din, mem_dout;
    logic          mem_owner, mem_we, core_reset_n, trigger_program, busy, error;

    int total = 0;
    int bad   = 0;

    mem_boot_loader #(
        .ADDR_WIDTH    (16),
        .DATA_WIDTH    (8),
        .DEPTH         (2048),
        .READ_LATENCY  (2),
        .TRIGGER_CYCLES(3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_base       (cmd_base),
        .cmd_len        (cmd_len),
        .cmd_fill       (cmd_fill),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .mem_owner      (mem_owner),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .core_reset_n   (core_reset_n),
        .trigger_program(trigger_program),
        .busy           (busy),
        .error          (error),
        .err_addr       (err_addr)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous RAM, two-cycle read latency, preloaded with a non-zero pattern.
    logic [DW-1:0] mem [0:2047];
    logic [DW-1:0] rd1, rd2;
    logic          init_mem;
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 8'hEE;
        end else if (mem_we && mem_owner) begin
            mem[mem_addr[10:0]] <= mem_din;
        end
        rd1 <= mem[mem_addr[10:0]];
        rd2 <= rd1;
    end
    assign mem_dout = rd2;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] base;
        logic [15:0] len;
        logic [7:0]  fill;
        int          n;
        logic [31:0] stream;
        int          exp_busy;
        logic        exp_err;
        logic [15:0] exp_err_addr;
    } cmd_vec_t;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } mem_vec_t;

    cmd_vec_t cmd_tab [8];
    mem_vec_t mem_tab [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [15:0] base,
                            input logic [15:0] len, input logic [7:0] fill);
        cmd_op    = op;
        cmd_base  = base;
        cmd_len   = len;
        cmd_fill  = fill;
        cmd_valid = 1'b1;
        #1;
        chk("cmd_ready_before_accept", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL timeout: simulation limit reached");
        $fatal(1);
    end

    initial begin
        int   wcnt, addr_bad, nz, stall_we, wbad, k, cyc, trig_cnt, we_bad, rdy_bad;
        logic hs;
        logic [31:0] words;

        cmd_tab[0] = '{2'd2, 16'h0600, 16'd4, 8'h00, 4, 32'hA9056903, 12, 1'b0, 16'h0000};
        cmd_tab[1] = '{2'd1, 16'h07FE, 16'd4, 8'h00, 4, 32'h11223344, 4, 1'b0, 16'h0000};
        cmd_tab[2] = '{2'd0, 16'h0010, 16'd3, 8'h5A, 0, 32'h0, 3, 1'b0, 16'h0000};
        cmd_tab[3] = '{2'd0, 16'h0020, 16'd0, 8'h77, 0, 32'h0, 0, 1'b0, 16'h0000};
        cmd_tab[4] = '{2'd2, 16'h07FF, 16'd2, 8'h00, 2, 32'h22330000, 6, 1'b0, 16'h0000};
        cmd_tab[5] = '{2'd2, 16'h080E, 16'd4, 8'h00, 4, 32'h00005A5A, 12, 1'b0, 16'h0000};
        cmd_tab[6] = '{2'd2, 16'h0600, 16'd4, 8'h00, 4, 32'hA9056803, 12, 1'b1, 16'h0602};
        cmd_tab[7] = '{2'd2, 16'h07FE, 16'd2, 8'h00, 2, 32'h00000000, 6, 1'b1, 16'h0602};

        mem_tab[0]  = '{16'h0600, 8'hA9};
        mem_tab[1]  = '{16'h0601, 8'h05};
        mem_tab[2]  = '{16'h0602, 8'h69};
        mem_tab[3]  = '{16'h0603, 8'h03};
        mem_tab[4]  = '{16'h07FE, 8'h11};
        mem_tab[5]  = '{16'h07FF, 8'h22};
        mem_tab[6]  = '{16'h0000, 8'h33};
        mem_tab[7]  = '{16'h0001, 8'h44};
        mem_tab[8]  = '{16'h0010, 8'h5A};
        mem_tab[9]  = '{16'h0011, 8'h5A};
        mem_tab[10] = '{16'h0012, 8'h5A};
        mem_tab[11] = '{16'h0013, 8'h00};
        mem_tab[12] = '{16'h0020, 8'h00};

        reset = 1'b1; init_mem = 1'b1; cmd_valid = 1'b0; s_valid = 1'b0;
        cmd_op = '0; cmd_base = '0; cmd_len = '0; cmd_fill = '0; s_data = '0;
        repeat (2) @(posedge clk);
        #1;
        init_mem = 1'b0;
        reset    = 1'b0;
        #1;
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_mem_owner", {31'b0, mem_owner}, 32'd1);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
        chk("rst_mem_din", {24'b0, mem_din}, 32'd0);
        chk("rst_core_reset_n", {31'b0, core_reset_n}, 32'd0);
        chk("rst_trigger", {31'b0, trigger_program}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_error", {31'b0, error}, 32'd0);
        chk("rst_err_addr", {16'b0, err_addr}, 32'd0);
        chk("rst_s_ready", {31'b0, s_ready}, 32'd0);

        // Full-depth fill: one write per cycle, busy drops on cycle 2049.
        send_cmd(2'd0, 16'h0000, 16'h0800, 8'h00);
        wcnt = 0; addr_bad = 0;
        for (int i = 0; i < 2048; i++) begin
            if (mem_we && busy && mem_din == 8'h00) wcnt++;
            if (mem_addr != 16'(i)) addr_bad++;
            @(posedge clk);
            #1;
        end
        chk("fill_writes", wcnt, 2048);
        chk("fill_addr_seq", addr_bad, 0);
        chk("fill_busy_drop", {31'b0, busy}, 32'd0);
        nz = 0;
        for (int i = 0; i < 2048; i++) if (mem[i] != 8'h00) nz++;
        chk("fill_all_zero", nz, 0);

        // Load with a two-cycle stream stall between words 2 and 3.
        send_cmd(2'd1, 16'h0600, 16'd4, 8'h00);
        words = 32'hA9056903; stall_we = 0; wbad = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                s_valid = 1'b0;
                repeat (2) begin
                    #1;
                    if (mem_we || !busy) stall_we++;
                    @(posedge clk);
                    #1;
                end
            end
            s_valid = 1'b1;
            s_data  = words[31-8*i -: 8];
            #1;
            if (!(mem_we && mem_addr == 16'h0600 + 16'(i) && mem_din == s_data)) wbad++;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        chk("load_stall_no_we", stall_we, 0);
        chk("load_write_beats", wbad, 0);
        chk("load_busy_drop", {31'b0, busy}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            send_cmd(cmd_tab[i].op, cmd_tab[i].base, cmd_tab[i].len, cmd_tab[i].fill);
            k = 0; cyc = 0;
            for (int t = 0; t < 200 && busy; t++) begin
                s_valid = (k < cmd_tab[i].n);
                s_data  = (k < 4) ? cmd_tab[i].stream[31-8*k -: 8] : 8'h00;
                #1;
                hs = s_valid && s_ready;
                cyc++;
                @(posedge clk);
                #1;
                if (hs) k++;
            end
            s_valid = 1'b0;
            chk($sformatf("vec%0d_busy_cycles", i), cyc, cmd_tab[i].exp_busy);
            chk($sformatf("vec%0d_consumed", i), k, cmd_tab[i].n);
            chk($sformatf("vec%0d_error", i), {31'b0, error}, {31'b0, cmd_tab[i].exp_err});
            chk($sformatf("vec%0d_err_addr", i), {16'b0, err_addr},
                {16'b0, cmd_tab[i].exp_err_addr});
        end

        for (int i = 0; i < 13; i++)
            chk($sformatf("mem_%0h", mem_tab[i].a), {24'b0, mem[mem_tab[i].a[10:0]]},
                {24'b0, mem_tab[i].d});

        // Start is refused while the verify error is set.
        send_cmd(2'd3, 16'h0000, 16'h0000, 8'h00);
        chk("start_err_core_reset_n", {31'b0, core_reset_n}, 32'd0);
        chk("start_err_mem_owner", {31'b0, mem_owner}, 32'd1);
        chk("start_err_trigger", {31'b0, trigger_program}, 32'd0);
        chk("start_err_cmd_ready", {31'b0, cmd_ready}, 32'd1);

        // Reset after two load words, colliding with an offered START.
        send_cmd(2'd1, 16'h0100, 16'd4, 8'h00);
        s_valid = 1'b1; s_data = 8'h01;
        @(posedge clk);
        #1;
        s_data = 8'h02;
        @(posedge clk);
        #1;
        s_valid = 1'b0; reset = 1'b1;
        cmd_op = 2'd3; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; cmd_valid = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_error", {31'b0, error}, 32'd0);
        chk("midrst_err_addr", {16'b0, err_addr}, 32'd0);
        chk("midrst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("midrst_mem_owner", {31'b0, mem_owner}, 32'd1);
        chk("midrst_core_reset_n", {31'b0, core_reset_n}, 32'd0);
        chk("midrst_mem_addr", {16'b0, mem_addr}, 32'd0);
        @(posedge clk);
        #1;
        chk("midrst_start_dropped", {31'b0, core_reset_n}, 32'd0);
        chk("midrst_mem_100", {24'b0, mem[11'h100]}, 32'h01);
        chk("midrst_mem_101", {24'b0, mem[11'h101]}, 32'h02);
        chk("midrst_mem_102", {24'b0, mem[11'h102]}, 32'h00);

        // Clean start: release core, three-cycle trigger, later commands ignored.
        send_cmd(2'd3, 16'h0000, 16'h0000, 8'h00);
        chk("run_mem_owner", {31'b0, mem_owner}, 32'd0);
        chk("run_core_reset_n", {31'b0, core_reset_n}, 32'd1);
        chk("run_trigger_first", {31'b0, trigger_program}, 32'd1);
        chk("run_s_ready", {31'b0, s_ready}, 32'd0);
        cmd_op = 2'd0; cmd_base = 16'h0000; cmd_len = 16'd5; cmd_fill = 8'hCC;
        cmd_valid = 1'b1;
        trig_cnt = 0; we_bad = 0; rdy_bad = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (trigger_program) trig_cnt++;
            if (mem_we || busy) we_bad++;
            if (cmd_ready) rdy_bad++;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        chk("run_trigger_cycles", trig_cnt, 3);
        chk("run_no_mem_we", we_bad, 0);
        chk("run_cmd_ready_low", rdy_bad, 0);
        chk("run_core_stays_released", {31'b0, core_reset_n}, 32'd1);
        chk("run_mem_untouched", {24'b0, mem[0]}, 32'h33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_boot_loader.md
Name: mem_boot_loader

Overview:
- Synthesisable replacement for the bench-driven memory preload and program launch.
- Holds the core in reset while it owns the memory port. Executes fill, load and verify commands over address ranges, then releases the core and pulses trigger_program.
- Sits between an external host/ROM stream and the mem port mux (manual_mem path).
- Generalised over address/data width, depth, read latency and trigger length.

Parameters:
- ADDR_WIDTH, 16, memory address width.
- DATA_WIDTH, 8, memory word width.
- DEPTH, 2048, number of valid words; addresses wrap modulo DEPTH.
- READ_LATENCY, 1, cycles from mem_addr to valid mem_dout (1..4).
- TRIGGER_CYCLES, 1, high duration of trigger_program (1..15).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_op  in  2  0=FILL, 1=LOAD, 2=VERIFY, 3=START.
- cmd_base  in  ADDR_WIDTH  first address (taken mod DEPTH).
- cmd_len  in  ADDR_WIDTH  word count; 0 = no-op.
- cmd_fill  in  DATA_WIDTH  constant for FILL.
- s_valid  in  1  stream word offered (LOAD data / VERIFY expected).
- s_ready  out  1  stream word consumed when valid&ready.
- s_data  in  DATA_WIDTH  stream word.
- mem_owner  out  1  1 = loader drives mem port (manual_mem).
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_din  out  DATA_WIDTH  memory write data.
- mem_dout  in  DATA_WIDTH  memory read data.
- core_reset_n  out  1  reset to CPU core, active-low.
- trigger_program  out  1  program start pulse (get_next).
- busy  out  1  FILL/LOAD/VERIFY in progress.
- error  out  1  sticky verify mismatch.
- err_addr  out  ADDR_WIDTH  address of first mismatch.

Behaviour:
- Reset values: state IDLE, mem_owner=1, mem_we=0, mem_addr=0, mem_din=0, core_reset_n=0, trigger_program=0, busy=0, error=0, err_addr=0, s_ready=0. cmd_ready=1 in IDLE.
- States: IDLE, FILL, LOAD, V_ISSUE, V_WAIT, V_CMP, RUN.
- IDLE: cmd_ready=1. On accept, latch base/len/fill and addr counter=base mod DEPTH, remaining=len.
  - len=0 with op 0..2: stay IDLE; the command is consumed.
  - START: go to RUN.
- FILL: one write per cycle; mem_we=1, mem_din=fill. After len writes, return to IDLE. No stream use.
- LOAD:
  - s_ready=1. Each s_valid&s_ready writes s_data to the current address that same cycle (mem_we=1).
  - s_valid=0 stalls: mem_we=0, counters hold.
  - After len words, return to IDLE.
- VERIFY, per word:
  - V_ISSUE drives mem_addr, mem_we=0.
  - V_WAIT lasts READ_LATENCY-1 cycles; skipped when READ_LATENCY=1.
  - V_CMP: s_ready=1. It waits for s_valid, then compares mem_dout with s_data.
  - Throughput is one word per READ_LATENCY+1 cycles with no stall.
  - First mismatch sets error=1 and err_addr=address. Later mismatches do not overwrite. Verify always consumes all len words.
- Address counter increments after each word. At DEPTH-1 it wraps to 0, so len>DEPTH revisits addresses.
- busy=1 in FILL/LOAD/V_*. cmd_ready=0 outside IDLE.
- START accepted at edge N:
  - From edge N+1, mem_owner=0, mem_we=0 and core_reset_n=1.
  - trigger_program=1 for exactly TRIGGER_CYCLES cycles starting at N+1.
- START with error=1: command consumed, stays IDLE, core_reset_n stays 0.
- RUN is terminal. cmd_ready=0 and s_ready=0; only reset leaves it.
- Reset mid-operation returns to IDLE with reset values next edge. Partial writes remain in memory. error is cleared.
- Simultaneous reset and cmd_valid: reset wins; command not accepted.
- mem_we never asserts while mem_owner=0.

Test Plan:
- FILL base=0x0000 len=0x0800 fill=0x00 -> 2048 writes in 2048 consecutive cycles, busy drops on cycle 2049, all mem reads 0x00.
- LOAD base=0x0600 len=4, stream A9 05 69 03 with s_valid low for 2 cycles between words 2 and 3 -> mem[0x600..0x603]=A9,05,69,03; mem_we low during the stall.
- VERIFY same range, READ_LATENCY=2, expected A9 05 68 03 -> error=1, err_addr=0x0602, all 4 words consumed, 12 cycles busy.
- LOAD base=0x07FE len=4 (DEPTH=2048) -> writes at 0x7FE, 0x7FF, 0x000, 0x001.
- START with error=0, TRIGGER_CYCLES=3 -> next cycle mem_owner=0, core_reset_n=1, trigger_program high 3 cycles; later cmd_valid ignored (cmd_ready=0). START after a failed verify -> core_reset_n stays 0.
- Assert reset during LOAD after word 2 -> next cycle IDLE, mem_owner=1, core_reset_n=0, error=0, cmd_ready=1.
